// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the fetch queue: FSM states, fetch-entry layout and defaults.
package fetch_queue_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries; clear wins over push and pop.
module fetch_fifo
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  fetch_entry_t    push_entry_i,
  input  logic            pop_i,
  input  logic            clear_i,
  output logic [CntW-1:0] count_o,
  output fetch_entry_t    head_o
);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_q, wr_d;
  logic [PtrW-1:0] rd_q, rd_d;
  logic [CntW-1:0] count_q, count_d;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (clear_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PtrW'(1);
      if (pop_i)  rd_d = rd_q + PtrW'(1);
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= push_entry_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: issues one imem request at a time, buffers responses and feeds the IF/ID
// register; redirects flush the buffer and discard any in-flight response.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        f_valid,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [CntW-1:0] count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            handshake;
  logic            push;
  logic            pop;

  // Credit check: only request when the buffer is guaranteed room for the response.
  assign imem_req_valid = (state_q == S_REQ) && (count < CntW'(DEPTH)) && !redirect_valid
                          && !reset;
  assign imem_req_addr  = pc_q;
  assign handshake      = imem_req_valid && imem_req_ready;

  assign push       = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop        = f_valid && !stall && !redirect_valid;
  assign push_entry = '{pc: req_pc_q, instr: imem_rsp_data};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    case (state_q)
      S_REQ: begin
        if (handshake) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid)      state_d = S_REQ;
        else if (redirect_valid) state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_valid) begin
      pc_d = align_word(redirect_pc);
    end else if (handshake) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .Depth(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (pop),
    .clear_i     (redirect_valid),
    .count_o     (count),
    .head_o      (head)
  );

  assign f_valid = (count != '0);
  assign f_instr = f_valid ? head.instr : NOP_INSTR;
  assign f_pc    = f_valid ? head.pc : 32'h0;

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Producer side of the IF/ID register: generates the fetch PC, issues instruction-memory requests and buffers returned {pc, instr} pairs.
- Presents the head pair to the decode-stage register and pops it when that register captures (stall low).
- Absorbs variable imem latency.
- Handles branch/jump redirects from decode by discarding in-flight and buffered fetches.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- DEPTH, 2, fetch buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- imem_req_valid  out  1  request to instruction memory
- imem_req_addr  out  32  word-aligned fetch address
- imem_req_ready  in  1  imem accepts request this cycle
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  returned instruction
- stall  in  1  decode register holding; no pop
- redirect_valid  in  1  control-flow redirect from decode
- redirect_pc  in  32  redirect target; bits [1:0] ignored
- f_valid  out  1  buffer head valid
- f_instr  out  32  head instruction; 32'h0 (nop) when empty
- f_pc  out  32  head PC; 32'h0 when empty

Behaviour:
- Reset values:
  - pc = RESET_PC, buffer empty, state = S_REQ.
  - imem_req_valid = 0 in the reset cycle.
  - f_valid = 0, f_instr = 0, f_pc = 0.
- Reset mid-transaction: any outstanding response is ignored from the next cycle onward (state S_REQ, no drop tracking).
- States:
  - S_REQ: may issue.
  - S_WAIT: one request outstanding.
  - S_DROP: one stale request outstanding, its response is to be discarded.
- At most one outstanding request at any time.
- Issue in S_REQ:
  - imem_req_valid = 1 when count + 0 < DEPTH and redirect_valid = 0.
  - imem_req_addr = pc.
  - Handshake on valid && ready: pc <= pc + 4 (wraps 32'hFFFF_FFFC -> 0), state -> S_WAIT.
  - Without ready, valid and addr stay stable.
- S_WAIT:
  - On imem_rsp_valid, push {pc_of_request, imem_rsp_data}, state -> S_REQ.
  - pc_of_request is held in an internal register.
- Credit rule: a request is only issued if the buffer has room for its response.
  - The response is always pushed and never overflows.
  - The same-cycle pop frees a slot; this is not needed for correctness.
- Pop: when f_valid && !stall, head advances at the clock edge.
- Simultaneous push and pop when full: illegal by the credit rule. When count = DEPTH-1, a simultaneous push and pop keep count unchanged.
- Output timing: f_* are registered buffer-head values, visible the cycle after the push.
  - Latency from response to f_valid: 1 cycle.
  - Best-case request-to-f_valid: 2 cycles with a single-cycle imem.
- Empty and !stall: decode captures nop (f_instr = 0, f_pc = 0).
- Redirect (redirect_valid = 1), highest priority over stall, push and pop:
  - Buffer cleared (count = 0).
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No request issued that cycle.
  - From S_WAIT without rsp_valid the same cycle -> S_DROP.
  - From S_WAIT with rsp_valid the same cycle: response discarded -> S_REQ.
  - From S_REQ -> S_REQ; a handshake is blocked because req_valid is low.
  - From S_DROP -> S_DROP (the stale response is still pending).
- S_DROP:
  - On rsp_valid, discard and go to S_REQ; no request issued in S_DROP.
  - A redirect while in S_DROP only updates pc.
- Delay-slot ordering is the issuer's responsibility: decode asserts redirect only after the delay-slot instruction is popped.
- imem_rsp_valid outside S_WAIT/S_DROP is ignored.

Decomposition:
- Shared package holds:
  - the state enum (S_REQ, S_WAIT, S_DROP);
  - NOP_INSTR = 32'h0;
  - RESET_PC default 32'h0000_3000;
  - the fetch-entry struct {pc[31:0], instr[31:0]}.
- One sub-module: fetch_fifo.
  - Circular buffer of DEPTH entries.
  - Ports: push, pop, clear, count, head.
  - Clear has priority over push/pop.

Test Plan:
- Reset then single-cycle imem (ready = 1, rsp the next cycle, data = addr ^ 32'hFFFF_0000), stall = 0 -> f_pc sequence 0x3000, 0x3004, 0x3008..., f_instr matches; f_valid = 0 for the first 2 cycles.
- stall = 1 for 10 cycles with continuous imem -> buffer fills to DEPTH; imem_req_valid drops to 0; f_pc holds 0x3000; release -> 0x3000, 0x3004 in order, none lost or duplicated.
- Redirect to 0x0000_4001 while in S_WAIT, response delayed 3 cycles -> late response discarded; next req addr 0x4000; first f_pc after redirect = 0x4000.
- Redirect in the same cycle as rsp_valid (data 0xDEADBEEF) -> 0xDEADBEEF never appears on f_instr; state S_REQ next cycle.
- imem_req_ready = 0 for 5 cycles -> req_valid stays 1 with addr stable at 0x3000; f_instr = 0, f_valid = 0 throughout.
- pc = 0xFFFF_FFFC via redirect -> following request addr 0x0000_0000; reset asserted in S_WAIT -> next request addr 0x3000 and the stale response is ignored.
